// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-size codes and FSM states shared by the data-memory responder
package dmem_responder_pkg;
   localparam logic [3:0] MEM_TYPE_BYTE = 4'b0001;
   localparam logic [3:0] MEM_TYPE_HALF = 4'b0011;
   localparam logic [3:0] MEM_TYPE_WORD = 4'b1111;
   typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store lane mask/replication, load lane select/extension and fault check
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [3:0]  acc_type,
   input  logic        sign,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wrep,
   output logic [31:0] rdata,
   output logic        fault
);
   logic [15:0] sh;
   assign fault = !(acc_type == MEM_TYPE_BYTE ||
                    (acc_type == MEM_TYPE_HALF && !addr_lo[0]) ||
                    (acc_type == MEM_TYPE_WORD && addr_lo == 2'b00));
   assign be    = fault ? 4'b0000 : acc_type << addr_lo;
   assign wrep  = acc_type == MEM_TYPE_BYTE ? {4{wdata[7:0]}} :
                  acc_type == MEM_TYPE_HALF ? {2{wdata[15:0]}} : wdata;
   assign sh    = 16'(rword >> {addr_lo, 3'b000});
   assign rdata = fault                      ? 32'h0 :
                  acc_type == MEM_TYPE_BYTE ? {{24{sign & sh[7]}}, sh[7:0]} :
                  acc_type == MEM_TYPE_HALF ? {{16{sign & sh[15]}}, sh[15:0]} : rword;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with configurable wait states
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [3:0]  i_req_type,
   input  logic        i_req_sign,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_misaligned
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   dmem_state_e state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic cap_we, cap_sign;
   logic [3:0] cap_type;
   logic [AW+1:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] mem [DEPTH_WORDS];
   logic idle, accept, load_rsp;
   logic sel_we, sel_sign;
   logic [3:0] sel_type;
   logic [AW+1:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0] be;
   logic [31:0] wrep, ldata;
   logic fault;
   logic unused_addr;
   assign unused_addr = ^i_req_addr[31:AW+2];
   assign idle        = state == DMEM_IDLE;
   assign accept      = idle && i_req_valid;
   assign o_req_ready = idle;
   assign o_rsp_valid = state == DMEM_RESP;
   // Live request while idle, captured request afterwards; the W=0 load reads on the accept edge
   assign sel_we    = idle ? i_req_we : cap_we;
   assign sel_sign  = idle ? i_req_sign : cap_sign;
   assign sel_type  = idle ? i_req_type : cap_type;
   assign sel_addr  = idle ? i_req_addr[AW+1:0] : cap_addr;
   assign sel_wdata = idle ? i_req_wdata : cap_wdata;
   dmem_lane_align u_align (
      .acc_type (sel_type),
      .sign     (sel_sign),
      .addr_lo  (sel_addr[1:0]),
      .wdata    (sel_wdata),
      .rword    (mem[sel_addr[AW+1:2]]),
      .be       (be),
      .wrep     (wrep),
      .rdata    (ldata),
      .fault    (fault)
   );
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load_rsp = 1'b0;
      case (state)
         DMEM_IDLE: if (i_req_valid) begin
            state_nx = WAIT_CYCLES > 0 ? DMEM_WAIT : DMEM_RESP;
            cnt_nx   = WLOAD;
            load_rsp = WAIT_CYCLES == 0;
         end
         DMEM_WAIT: begin
            cnt_nx = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            if (cnt == 4'd0) begin
               state_nx = DMEM_RESP;
               load_rsp = 1'b1;
            end
         end
         DMEM_RESP: state_nx = i_rsp_ready ? DMEM_IDLE : DMEM_RESP;
         default:   state_nx = DMEM_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= DMEM_IDLE;
         cnt              <= '0;
         cap_we           <= 1'b0;
         cap_sign         <= 1'b0;
         cap_type         <= '0;
         cap_addr         <= '0;
         cap_wdata        <= '0;
         o_rsp_rdata      <= '0;
         o_rsp_misaligned <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            cap_we    <= i_req_we;
            cap_sign  <= i_req_sign;
            cap_type  <= i_req_type;
            cap_addr  <= i_req_addr[AW+1:0];
            cap_wdata <= i_req_wdata;
         end
         if (load_rsp) begin
            o_rsp_rdata      <= sel_we ? 32'h0 : ldata;
            o_rsp_misaligned <= fault;
         end else if (state == DMEM_RESP && i_rsp_ready) begin
            o_rsp_rdata      <= '0;
            o_rsp_misaligned <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (accept && sel_we && be[b])
            mem[sel_addr[AW+1:2]][b*8 +: 8] <= wrep[b*8 +: 8];
   end
endmodule
